// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through transmit buffer feeding uart_tx.
// Circular buffer of DEPTH x DATA_WIDTH entries. The pointers carry one extra
// wrap bit, so full and empty can be told apart without a separate counter.
// Optional feature: define UART_TX_FIFO_OVF_EN to build the sticky overflow
// flag. Without it, ovf is tied low and ovf_clr is ignored.

module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       level,
  input  logic                         flush,
  output logic                         tx_valid,
  output logic [DATA_WIDTH-1:0]        tx_data,
  input  logic                         tx_ready,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int LB_DEPTH = $clog2(DEPTH);
  localparam int PW       = LB_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Status decode from the registered pointers only. This keeps wr_en out of
  // the path to full, and tx_ready out of the path to tx_valid.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[LB_DEPTH-1:0] == rd_ptr_q[LB_DEPTH-1:0]) &&
               (wr_ptr_q[LB_DEPTH] != rd_ptr_q[LB_DEPTH]);
    level    = wr_ptr_q - rd_ptr_q;
    tx_valid = !empty;
    tx_data  = mem_q[rd_ptr_q[LB_DEPTH-1:0]];
  end

  // Push and pop qualification. Flush overrides both. full is sampled before
  // any pop, so a push into a full buffer is dropped even while popping.
  always_comb begin
    push     = wr_en && !full && !flush;
    pop      = tx_valid && tx_ready && !flush;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? wr_ptr_q : (rd_ptr_q + PW'(pop));
  end

  // Pointer registers. Asynchronous reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array. It has no reset, because entries outside the
  // rd..wr window are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[LB_DEPTH-1:0]] <= wr_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a push dropped while not flushing sets the flag.
  // Set wins over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full && !flush) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DATA_WIDTH=8, DEPTH=16).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] level;
  logic       flush;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;
  logic exp_ovf_en;

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .flush    (flush),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       do_wr, do_rd;

  initial begin
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf_en = 1'b1;
`else
    exp_ovf_en = 1'b0;
`endif
    rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_valid", tx_valid, 0);
    chk("rst_full",  full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf",   ovf, 0);
    rstn = 1'b1;
    step();

    // Single push, then single pop.
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("one_valid", tx_valid, 1);
    chk("one_data",  tx_data, 8'hA5);
    chk("one_level", level, 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("one_pop_valid", tx_valid, 0);
    chk("one_pop_level", level, 0);

    // Fill to DEPTH, overflow push, overflow flag behaviour.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("fill_full",  full, 1);
    chk("fill_level", level, 16);
    chk("fill_ovf0",  ovf, 0);
    wr_en = 1'b1; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("drop_level", level, 16);
    chk("drop_ovf",   ovf, exp_ovf_en);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'hFE;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, exp_ovf_en);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr2", ovf, 0);
    chk("hold_level", level, 16);

    // Drain: expect 0x00..0x0F in order.
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), tx_data, 32'(i));
      if (i == 0) begin
        step();
        chk("full_drop_after_pop", full, 0);
      end else begin
        step();
      end
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 0);
    chk("drain_level", level, 0);

    // Full push+pop: only the pop happens.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b1; wr_data = 8'hEE; tx_ready = 1'b1;
    step();
    wr_en = 1'b0; tx_ready = 1'b0;
    chk("fullpp_level", level, 15);
    chk("fullpp_head",  tx_data, 8'h11);
    tx_ready = 1'b1;
    repeat (7) step();
    tx_ready = 1'b0;
    chk("mid_level", level, 8);
    wr_en = 1'b1; wr_data = 8'h77; tx_ready = 1'b1;
    step();
    wr_en = 1'b0; tx_ready = 1'b0;
    chk("midpp_level", level, 8);
    chk("midpp_head",  tx_data, 8'h19);

    // Flush overrides a simultaneous push and pop.
    flush = 1'b1; wr_en = 1'b1; tx_ready = 1'b1; wr_data = 8'h42;
    step();
    flush = 1'b0; wr_en = 1'b0; tx_ready = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", tx_valid, 0);

    // 40 mixed cycles against a queue scoreboard; pointers wrap repeatedly.
    for (int i = 0; i < 40; i++) begin
      do_wr = (i % 3) != 2;
      do_rd = (i % 2) == 1;
      wr_en = do_wr; wr_data = 8'(i * 7 + 3); tx_ready = do_rd;
      #1;
      chk($sformatf("mix_level_%0d", i), level, 32'(q.size()));
      if (q.size() > 0) chk($sformatf("mix_data_%0d", i), tx_data, q[0]);
      else              chk($sformatf("mix_valid_%0d", i), tx_valid, 0);
      if (do_rd && q.size() > 0) void'(q.pop_front());
      if (do_wr && q.size() + (do_rd ? 1 : 0) <= 16 && !(q.size() == 16)) q.push_back(8'(i * 7 + 3));
      step();
    end
    wr_en = 1'b0; tx_ready = 1'b1;
    while (q.size() > 0) begin
      chk("mix_drain", tx_data, q[0]);
      void'(q.pop_front());
      step();
    end
    tx_ready = 1'b0;
    chk("mix_empty", tx_valid, 0);

    // Three back-to-back pushes, one pop, then asynchronous reset mid-cycle.
    wr_en = 1'b1; wr_data = 8'h55; step();
    wr_data = 8'h3C; step();
    wr_data = 8'h81; step();
    wr_en = 1'b0; tx_ready = 1'b1; step();
    tx_ready = 1'b0;
    chk("burst_level", level, 2);
    chk("burst_head",  tx_data, 8'h3C);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", tx_valid, 0);
    chk("arst_full",  full, 0);
    #10;
    rstn = 1'b1;
    step();
    chk("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
